// File: rtl/systolic_pkg.sv
// Shared types, widths and arithmetic helpers for the systolic matrix-multiply array.
package systolic_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

  localparam int unsigned K_W   = 16;
  localparam int unsigned MAX_W = 130;

  function automatic int unsigned flush_len(input int unsigned size);
    return 2 * size - 1;
  endfunction

  // Adds at MAX_W (never overflows for supported widths) and clamps to a signed acc_w range.
  function automatic logic signed [MAX_W-1:0] sat_add(input logic signed [MAX_W-1:0] a,
                                                      input logic signed [MAX_W-1:0] b,
                                                      input int unsigned acc_w);
    logic signed [MAX_W-1:0] sum;
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    sum = a + b;
    hi  = MAX_W'(1) <<< (acc_w - 1);
    lo  = -hi;
    hi  = hi - MAX_W'(1);
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// Output-stationary MAC cell: forwards a right and b down, accumulates a*b per step.
// SYSTOLIC_SAT_EN selects saturating accumulation with a sticky clamp flag; otherwise it wraps.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ACC_W  = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     step,
  input  logic                     clr,
  input  logic signed [DATA_W-1:0] a_in,
  input  logic signed [DATA_W-1:0] b_in,
  output logic signed [DATA_W-1:0] a_out,
  output logic signed [DATA_W-1:0] b_out,
  output logic signed [ACC_W-1:0]  acc,
  output logic                     ovf
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned SUM_W  = ((PROD_W > ACC_W) ? PROD_W : ACC_W) + 1;

  logic signed [PROD_W-1:0] prod_c;
  logic signed [SUM_W-1:0]  sum_c;
  logic signed [ACC_W-1:0]  acc_d;
  logic                     clamp_c;

  assign prod_c = PROD_W'(a_in) * PROD_W'(b_in);
  assign sum_c  = SUM_W'(prod_c) + SUM_W'(acc);

`ifdef SYSTOLIC_SAT_EN
  logic signed [MAX_W-1:0] sat_c;
  assign sat_c   = sat_add(MAX_W'(acc), MAX_W'(prod_c), ACC_W);
  assign acc_d   = ACC_W'(sat_c);
  assign clamp_c = (sat_c != MAX_W'(sum_c));
`else
  logic unused_sum_hi;
  assign acc_d         = ACC_W'(sum_c);
  assign clamp_c       = 1'b0;
  assign unused_sum_hi = ^sum_c[SUM_W-1:ACC_W];
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
      ovf   <= 1'b0;
    end else if (step) begin
      a_out <= a_in;
      b_out <= b_in;
      acc   <= acc_d;
      ovf   <= ovf | clamp_c;
    end
  end

endmodule

// File: rtl/systolic_mm_array.sv
// SIZE x SIZE output-stationary systolic matmul: input skew, job FSM, row-by-row drain.
// Define SYSTOLIC_SAT_EN for saturating accumulators and a live OVF flag.
module systolic_mm_array
  import systolic_pkg::*;
#(
  parameter int unsigned SIZE   = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ACC_W  = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     EN,
  input  logic                     START,
  input  logic [K_W-1:0]           K_LEN,
  output logic                     BUSY,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic [SIZE*DATA_W-1:0]   A_COL,
  input  logic [SIZE*DATA_W-1:0]   B_ROW,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic [SIZE*ACC_W-1:0]    OUT_ROW,
  output logic [$clog2(SIZE)-1:0]  OUT_IDX,
  output logic                     OUT_LAST,
  output logic                     OVF
);

  localparam int unsigned IDX_W = $clog2(SIZE);
  localparam int unsigned ROW_W = SIZE * ACC_W;
  localparam logic [K_W-1:0] FLUSH_CNT = K_W'(flush_len(SIZE) - 1);

  state_t            state_q, state_d;
  logic [K_W-1:0]    cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              step_c, clr_c, inject_c;

  logic signed [DATA_W-1:0] a_edge [SIZE];
  logic signed [DATA_W-1:0] b_edge [SIZE];
  logic signed [DATA_W-1:0] a_link [SIZE][SIZE];
  logic signed [DATA_W-1:0] b_link [SIZE][SIZE];
  logic signed [ACC_W-1:0]  pe_acc [SIZE][SIZE];
  logic [SIZE*SIZE-1:0]     pe_ovf;
  logic [SIZE-1:0][ROW_W-1:0] acc_rows;
  logic [SIZE-1:0]          unused_a_edge, unused_b_edge;

  // Row i of A and column i of B are delayed i steps before entering the array.
  for (genvar i = 0; i < SIZE; i++) begin : g_skew
    logic signed [DATA_W-1:0] a_new, b_new;
    assign a_new = inject_c ? signed'(A_COL[i*DATA_W +: DATA_W]) : '0;
    assign b_new = inject_c ? signed'(B_ROW[i*DATA_W +: DATA_W]) : '0;

    if (i == 0) begin : g_direct
      assign a_edge[i] = a_new;
      assign b_edge[i] = b_new;
    end else begin : g_delay
      logic signed [DATA_W-1:0] a_sh_q [i];
      logic signed [DATA_W-1:0] b_sh_q [i];
      always_ff @(posedge CLK or posedge RST) begin
        if (RST || clr_c) begin
          for (int s = 0; s < i; s++) begin
            a_sh_q[s] <= '0;
            b_sh_q[s] <= '0;
          end
        end else if (step_c) begin
          a_sh_q[0] <= a_new;
          b_sh_q[0] <= b_new;
          for (int s = 1; s < i; s++) begin
            a_sh_q[s] <= a_sh_q[s-1];
            b_sh_q[s] <= b_sh_q[s-1];
          end
        end
      end
      assign a_edge[i] = a_sh_q[i-1];
      assign b_edge[i] = b_sh_q[i-1];
    end

    assign unused_a_edge[i] = ^a_link[i][SIZE-1];
    assign unused_b_edge[i] = ^b_link[SIZE-1][i];
  end

  for (genvar r = 0; r < SIZE; r++) begin : g_row
    for (genvar c = 0; c < SIZE; c++) begin : g_col
      logic signed [DATA_W-1:0] a_in_w, b_in_w;
      if (c == 0) begin : g_a_edge
        assign a_in_w = a_edge[r];
      end else begin : g_a_link
        assign a_in_w = a_link[r][c-1];
      end
      if (r == 0) begin : g_b_edge
        assign b_in_w = b_edge[c];
      end else begin : g_b_link
        assign b_in_w = b_link[r-1][c];
      end

      systolic_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .CLK   (CLK),
        .RST   (RST),
        .step  (step_c),
        .clr   (clr_c),
        .a_in  (a_in_w),
        .b_in  (b_in_w),
        .a_out (a_link[r][c]),
        .b_out (b_link[r][c]),
        .acc   (pe_acc[r][c]),
        .ovf   (pe_ovf[r*SIZE+c])
      );

      assign acc_rows[r][c*ACC_W +: ACC_W] = pe_acc[r][c];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    valid_d  = valid_q;
    last_d   = last_q;
    idx_d    = idx_q;
    row_d    = row_q;
    step_c   = 1'b0;
    clr_c    = 1'b0;
    inject_c = 1'b0;
    if (EN) begin
      unique case (state_q)
        IDLE: begin
          if (START) begin
            clr_c  = 1'b1;
            busy_d = 1'b1;
            if (K_LEN == '0) begin
              state_d = FLUSH;
              cnt_d   = FLUSH_CNT;
            end else begin
              state_d = LOAD;
              cnt_d   = K_LEN;
            end
          end
        end
        LOAD: begin
          if (IN_VALID) begin
            step_c   = 1'b1;
            inject_c = 1'b1;
            cnt_d    = cnt_q - K_W'(1);
            if (cnt_q == K_W'(1)) begin
              state_d = FLUSH;
              cnt_d   = FLUSH_CNT;
            end
          end
        end
        FLUSH: begin
          step_c = 1'b1;
          if (cnt_q == '0) state_d = DRAIN;
          else             cnt_d   = cnt_q - K_W'(1);
        end
        DRAIN: begin
          // First DRAIN cycle latches row 0; afterwards each handshake advances one row.
          if (!valid_q) begin
            valid_d = 1'b1;
            idx_d   = '0;
            last_d  = 1'b0;
            row_d   = acc_rows[0];
          end else if (OUT_READY) begin
            if (last_q) begin
              state_d = IDLE;
              busy_d  = 1'b0;
              valid_d = 1'b0;
              last_d  = 1'b0;
              idx_d   = '0;
            end else begin
              idx_d  = idx_q + IDX_W'(1);
              last_d = (idx_d == IDX_W'(SIZE - 1));
              row_d  = acc_rows[idx_d];
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      row_q   <= row_d;
    end
  end

  assign BUSY      = busy_q;
  assign IN_READY  = EN && (state_q == LOAD);
  assign OUT_VALID = valid_q;
  assign OUT_ROW   = row_q;
  assign OUT_IDX   = idx_q;
  assign OUT_LAST  = last_q;
  assign OVF       = |pe_ovf;

endmodule

// File: doc/systolic_mm_array.md
# systolic_mm_array

Parametrised SIZE×SIZE output-stationary systolic matrix-multiply array. It is the successor to the fixed 2×2 `SYSTOLIC` tile. It adds internal input skewing, a job-level FSM with a K-length streamed inner dimension, valid/ready input and output handshakes, and row-by-row result drain. It sits between the operand buffers (A columns, B rows) and the result writeback path.

## Interface
- `SIZE`, default 4: array edge; PE count is SIZE×SIZE; must be ≥ 2.
- `DATA_W`, default 32: signed operand width.
- `ACC_W`, default 32: signed accumulator/result width.
- `CLK`  in  1  rising-edge clock.
- `RST`  in  1  asynchronous, active-high reset.
- `EN`  in  1  global enable; when low, all state holds.
- `START`  in  1  job start; sampled only in IDLE.
- `K_LEN`  in  16  inner-dimension length; sampled with START.
- `BUSY`  out  1  high in every state except IDLE.
- `IN_VALID`  in  1  operand beat valid.
- `IN_READY`  out  1  operand beat accepted when high together with IN_VALID.
- `A_COL`  in  SIZE*DATA_W  column k of A; element i occupies bits [i*DATA_W +: DATA_W].
- `B_ROW`  in  SIZE*DATA_W  row k of B; element j occupies bits [j*DATA_W +: DATA_W].
- `OUT_VALID`  out  1  result row valid.
- `OUT_READY`  in  1  downstream accepts the row.
- `OUT_ROW`  out  SIZE*ACC_W  row OUT_IDX of C; element j occupies bits [j*ACC_W +: ACC_W].
- `OUT_IDX`  out  $clog2(SIZE)  index of the current result row.
- `OUT_LAST`  out  1  high with row SIZE-1.
- `OVF`  out  1  sticky per-job saturation flag (see Configuration).

## Operation
- FSM states: IDLE → LOAD → FLUSH → DRAIN → IDLE.
- **IDLE**
  - START with EN high clears all accumulators, the skew registers and OVF.
  - Latches K_LEN into the beat counter.
  - Next state is LOAD, or FLUSH if K_LEN = 0.
- **LOAD**
  - IN_READY = EN.
  - Each accepted beat advances the array one step and decrements the counter.
  - Moves to FLUSH after beat K_LEN is accepted.
  - No beat means no step: the array freezes and does not inject bubbles.
- **FLUSH**
  - The array steps every EN cycle with zero operands injected.
  - Lasts exactly 2*SIZE-1 enabled cycles, then moves to DRAIN.
- **DRAIN**
  - OUT_VALID = 1.
  - OUT_ROW = accumulator row OUT_IDX, starting at 0.
  - Each handshake with EN high increments OUT_IDX.
  - The handshake on OUT_LAST returns the FSM to IDLE.
- **Skew**
  - Row i of A is delayed i steps; column j of B is delayed j steps.
  - A values propagate right and B values propagate down, one PE per step.
- **PE step**
  - acc += a*b.
  - The product is formed at 2*DATA_W signed width.
  - The sum is formed at max(2*DATA_W, ACC_W)+1 bits, then reduced to ACC_W.
  - Default reduction is wrap, i.e. modulo 2^ACC_W.
- START outside IDLE is ignored.
- IN_VALID outside LOAD is ignored.
- RST at any point returns the FSM to IDLE and clears all state and outputs.

## Timing
- Reset values:
  - BUSY, IN_READY, OUT_VALID, OUT_LAST, OVF = 0.
  - OUT_IDX = 0; OUT_ROW = 0.
- BUSY rises the cycle after START is accepted.
- With no stalls, the first OUT_VALID occurs K_LEN + 2*SIZE cycles after that START edge.
- Each DRAIN row is held stable until its handshake; with OUT_READY tied high, one row is emitted per cycle.
- EN low:
  - IN_READY is low and no handshake completes.
  - OUT_VALID/OUT_ROW/OUT_IDX hold their values.
  - FSM and counters freeze.
- A new START is accepted no earlier than the cycle after BUSY falls.

## Configuration
- `SYSTOLIC_SAT_EN` defined:
  - Accumulation saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - OVF sets on any clamp in any PE and holds until the next accepted START or RST.
- Not defined:
  - Accumulation wraps.
  - OVF is tied to 0.

## Structure
- Package `systolic_pkg` holds:
  - `state_t` enum (IDLE, LOAD, FLUSH, DRAIN).
  - `K_W` = 16.
  - Function `flush_len(size)` = 2*size-1.
  - The saturating-add function.
- Sub-module `systolic_pe`:
  - Ports: CLK, RST, step, clr, a_in, b_in, a_out, b_out, acc, ovf.
  - Instantiated SIZE×SIZE times.
- Skew registers, FSM and drain mux live in the top module.

## Test plan
- **2×2 basic multiply.** SIZE=2, K_LEN=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]]; beats (A_COL,B_ROW) = ((1,3),(5,6)), ((2,4),(7,8)). Required: rows [19,22] then [43,50]; OUT_LAST on row 1; BUSY low afterwards.
- **Input stalls.** Same job with IN_VALID deasserted 3 cycles between beats. Required: identical results; first OUT_VALID delayed by exactly 3 cycles.
- **Backpressure and EN.** SIZE=4, identity A × B=ramp(1..16); hold OUT_READY low 5 cycles on row 2, and drop EN 2 cycles mid-FLUSH. Required: rows equal B unchanged; row 2 held stable until its handshake.
- **K_LEN=0 and ignored START.** K_LEN=0 → four all-zero rows after 2*SIZE cycles. START pulsed during LOAD → ignored, no state change.
- **Reset mid-job.** RST asserted in FLUSH. Required: all outputs 0 immediately. A following job (1×1 entries, K_LEN=3) yields all 3s.
- **Overflow.** DATA_W=ACC_W=8, K_LEN=2, all operands 127.
  - With SYSTOLIC_SAT_EN: all results 127, OVF=1.
  - Without: results (2*16129) mod 256 = 2, OVF=0.
